// File: rtl/pmips_pkg.sv
// Shared pmips definitions: widths, NOP encoding, instruction field helpers, fetch FSM states.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package pmips_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  // Opcode values held in instr[15:13]
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [2:0] f_opcode(input logic [INSTR_W-1:0] instr);
    return instr[15:13];
  endfunction

  function automatic logic [2:0] f_rs(input logic [INSTR_W-1:0] instr);
    return instr[12:10];
  endfunction

  function automatic logic [2:0] f_rt(input logic [INSTR_W-1:0] instr);
    return instr[9:7];
  endfunction

  function automatic logic [6:0] f_imm(input logic [INSTR_W-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: fetched instruction, its address+2 and a valid flag.
// Latency: 1 cycle from load to outputs.
// Backpressure: hold when neither load nor flush; flush beats load and keeps pc_plus2.
module if_id_reg
  import pmips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_plus2_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus2,
  output logic               valid
);

  // Reset clears to a NOP bubble; flush inserts a bubble without touching pc_plus2.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr    <= NOP;
      pc_plus2 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_in;
      pc_plus2 <= pc_plus2_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register drives iaddr, returned word is captured into IF/ID.
// Latency: 1 cycle from iaddr to ifid_instr.
// Backpressure: stall freezes PC, IF/ID and counter; redirect overrides stall and flushes.
module fetch_stage
  import pmips_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] iaddr,
  input  logic [15:0] idata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic [15:0] fetch_count
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next_seq;
  logic              do_load;

  assign iaddr       = pc;
  assign pc_next_seq = pc + STEP;

  // A fetch is accepted unless redirected; the BOOT cycle ignores stall because its lookup must complete.
  always_comb begin
    do_load = 1'b0;
    if (!redirect) begin
      do_load = (state == BOOT) || !stall;
    end
  end

  // PC, FSM and saturating accepted-instruction counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state <= RUN;
      if (redirect) begin
        pc <= {redirect_target[15:1], 1'b0};
      end else if (do_load) begin
        pc <= pc_next_seq;
        if (fetch_count != 16'hFFFF) begin
          fetch_count <= fetch_count + 16'd1;
        end
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clock       (clock),
    .reset       (reset),
    .load        (do_load),
    .flush       (redirect),
    .instr_in    (idata),
    .pc_plus2_in (pc_next_seq),
    .instr       (ifid_instr),
    .pc_plus2    (ifid_pc_plus2),
    .valid       (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a behavioural fetch model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: stall/redirect driven by directed and random steps.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic [15:0] iaddr;
  logic [15:0] idata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_target;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:32767];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_pc, m_instr, m_pp2, m_cnt;
  logic        m_valid, m_boot;

  fetch_stage #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .iaddr           (iaddr),
    .idata           (idata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_instr      (ifid_instr),
    .ifid_pc_plus2   (ifid_pc_plus2),
    .ifid_valid      (ifid_valid),
    .fetch_count     (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: combinational read, word addressed by byte address.
  assign idata = mem[iaddr[15:1]];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".iaddr"}, iaddr, m_pc);
    chk({tag, ".instr"}, ifid_instr, m_instr);
    chk({tag, ".pp2"}, ifid_pc_plus2, m_pp2);
    chk({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, m_valid});
    chk({tag, ".count"}, fetch_count, m_cnt);
  endtask

  // Drive one cycle of inputs, advance the model by the fetch rules, wait past the edge.
  task automatic step(input logic rst, input logic stl, input logic rd, input logic [15:0] tgt);
    reset = rst; stall = stl; redirect = rd; redirect_target = tgt;
    if (rst) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
      m_valid = 1'b0; m_cnt = 16'h0000; m_boot = 1'b1;
    end else if (rd) begin
      m_pc = tgt & 16'hFFFE; m_instr = 16'h0000; m_valid = 1'b0; m_boot = 1'b0;
    end else if (stl && !m_boot) begin
      // everything holds
    end else begin
      m_instr = mem[m_pc >> 1];
      m_pp2   = m_pc + 16'd2;
      m_valid = 1'b1;
      m_pc    = m_pc + 16'd2;
      if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_boot  = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] t;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h6103;
    mem[1] = 16'h62A0;
    mem[2] = 16'h6A91;
    mem[3] = 16'hAA22;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 16'h0000;
    @(negedge clock);

    // Reset and BOOT cycle
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check_all("reset");
    chk("boot.iaddr", iaddr, 16'h0000);
    chk("boot.valid", {15'd0, ifid_valid}, 16'h0000);

    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("edge1");
    chk("edge1.instr_lit", ifid_instr, 16'h6103);
    chk("edge1.pp2_lit", ifid_pc_plus2, 16'h0002);
    chk("edge1.count_lit", fetch_count, 16'd1);

    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("edge2.instr_lit", ifid_instr, 16'h62A0);
    chk("edge2.pp2_lit", ifid_pc_plus2, 16'h0004);
    chk("edge2.count_lit", fetch_count, 16'd2);

    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("edge3");

    // Stall held three cycles at pc=0006
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      check_all("stall");
      chk("stall.iaddr_lit", iaddr, 16'h0006);
      chk("stall.instr_lit", ifid_instr, 16'h6A91);
      chk("stall.count_lit", fetch_count, 16'd3);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("unstall.instr_lit", ifid_instr, 16'hAA22);
    chk("unstall.pp2_lit", ifid_pc_plus2, 16'h0008);

    // Redirect overrides stall
    step(1'b0, 1'b1, 1'b1, 16'h0010);
    check_all("redir");
    chk("redir.iaddr_lit", iaddr, 16'h0010);
    chk("redir.instr_lit", ifid_instr, 16'h0000);
    chk("redir.count_lit", fetch_count, 16'd4);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("post_redir");
    chk("post_redir.pp2_lit", ifid_pc_plus2, 16'h0012);

    // Odd target aligned down
    step(1'b0, 1'b0, 1'b1, 16'h0013);
    chk("odd.iaddr_lit", iaddr, 16'h0012);

    // Wrap from FFFE
    step(1'b0, 1'b0, 1'b1, 16'hFFFE);
    check_all("to_fffe");
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("wrap1");
    chk("wrap1.pp2_lit", ifid_pc_plus2, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("wrap2.iaddr_lit", iaddr, 16'h0002);

    // Random traffic including BOOT-cycle stalls/redirects
    for (int i = 0; i < 400; i++) begin
      t = 16'($urandom);
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), t);
      check_all("rand");
    end

    // Reset dominates stall and redirect while running at 000C
    step(1'b0, 1'b0, 1'b1, 16'h000C);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h000C);
    chk("pre_rst.iaddr_lit", iaddr, 16'h000C);
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    check_all("mid_rst");
    chk("mid_rst.iaddr_lit", iaddr, 16'h0000);
    chk("mid_rst.count_lit", fetch_count, 16'h0000);
    // Stall in BOOT is ignored, which shows the FSM is in BOOT
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check_all("boot_stall");
    chk("boot_stall.instr_lit", ifid_instr, 16'h6103);

    // Saturation of fetch_count
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 65534; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("cnt_fffe");
    chk("cnt_fffe.lit", fetch_count, 16'hFFFE);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("cnt_ffff.lit", fetch_count, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("cnt_sat");
    chk("cnt_sat.lit", fetch_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
